wishbone_mst_bus_if: RTL

//  CPU-side Wishbone master. Converts a single-cycle pipeline memory request (ce/we/addr/data/sel) into one

---
 rtl/wishbone_mst_bus_if_pkg.sv | 10 +
 rtl/wishbone_mst_timeout.sv | 30 +++
 rtl/wishbone_mst_bus_if.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wishbone_mst_bus_if_pkg.sv
// rtl/wishbone_mst_bus_if_pkg.sv - state encodings shared by the Wishbone master slice
package wishbone_mst_bus_if_pkg;

  typedef enum logic [1:0] {
    WB_ST_IDLE       = 2'b00,
    WB_ST_BUSY       = 2'b01,
    WB_ST_WAIT_STALL = 2'b10
  } wb_state_t;

endpackage

// File: rtl/wishbone_mst_timeout.sv
// rtl/wishbone_mst_timeout.sv - BUSY-cycle watchdog for the Wishbone master
module wishbone_mst_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Fires in the TIMEOUT_CYCLES-th consecutive BUSY cycle that sees no ack.
  assign expired = busy && !ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy && !ack && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_mst_bus_if.sv
// rtl/wishbone_mst_bus_if.sv - pipeline-to-Wishbone classic master (timeout abort under WB_MST_TIMEOUT_EN)
module wishbone_mst_bus_if
  import wishbone_mst_bus_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int STALL_WIDTH    = 6,
  parameter int STALL_BIT      = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   flush_i,
  input  logic                   cpu_ce_i,
  input  logic                   cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]  cpu_data_i,
  input  logic [SEL_WIDTH-1:0]   cpu_sel_i,
  output logic [DATA_WIDTH-1:0]  cpu_data_o,
  output logic                   stallreq_o,
  output logic                   wishbone_cyc_o,
  output logic                   wishbone_stb_o,
  output logic                   wishbone_we_o,
  output logic [ADDR_WIDTH-1:0]  wishbone_addr_o,
  output logic [DATA_WIDTH-1:0]  wishbone_data_o,
  output logic [SEL_WIDTH-1:0]   wishbone_sel_o,
  input  logic [DATA_WIDTH-1:0]  wishbone_data_i,
  input  logic                   wishbone_ack_i,
  output logic                   bus_err_o
);

  wb_state_t             state;
  logic [DATA_WIDTH-1:0] rd_buf;
  logic                  accept;
  logic                  timeout;
  logic                  abort;
  logic                  stage_held;
  logic                  unused_stall;

  assign stage_held   = stall_i[STALL_BIT];
  assign unused_stall = ^stall_i;
  assign accept       = (state == WB_ST_IDLE) && cpu_ce_i && !flush_i;

`ifdef WB_MST_TIMEOUT_EN
  logic in_busy;
  assign in_busy = (state == WB_ST_BUSY);

  wishbone_mst_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .busy   (in_busy),
    .ack    (wishbone_ack_i),
    .expired(timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A timeout is handled exactly like a flush; flush also wins over a same-cycle ack.
  assign abort     = flush_i || timeout;
  assign bus_err_o = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= WB_ST_IDLE;
      wishbone_cyc_o  <= 1'b0;
      wishbone_stb_o  <= 1'b0;
      wishbone_we_o   <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_sel_o  <= '0;
      rd_buf          <= '0;
    end else if (abort) begin
      state          <= WB_ST_IDLE;
      wishbone_cyc_o <= 1'b0;
      wishbone_stb_o <= 1'b0;
      wishbone_we_o  <= 1'b0;
      rd_buf         <= '0;
    end else begin
      case (state)
        WB_ST_IDLE: begin
          if (cpu_ce_i) begin
            wishbone_cyc_o  <= 1'b1;
            wishbone_stb_o  <= 1'b1;
            wishbone_we_o   <= cpu_we_i;
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_sel_o  <= cpu_sel_i;
            state           <= WB_ST_BUSY;
          end
        end
        WB_ST_BUSY: begin
          if (wishbone_ack_i) begin
            wishbone_cyc_o <= 1'b0;
            wishbone_stb_o <= 1'b0;
            wishbone_we_o  <= 1'b0;
            rd_buf         <= wishbone_data_i;
            state          <= stage_held ? WB_ST_WAIT_STALL : WB_ST_IDLE;
          end
        end
        WB_ST_WAIT_STALL: begin
          if (!stage_held) state <= WB_ST_IDLE;
        end
        default: state <= WB_ST_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the pipeline is released the instant reset asserts.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (rst_n && !abort) begin
      case (state)
        WB_ST_IDLE: stallreq_o = cpu_ce_i;
        WB_ST_BUSY: begin
          stallreq_o = !wishbone_ack_i;
          if (wishbone_ack_i) cpu_data_o = wishbone_data_i;
        end
        WB_ST_WAIT_STALL: cpu_data_o = rd_buf;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

endmodule
